sr_bank_driver: RTL and testbench
=================================

Name: sr_bank_driver

Overview:
- Initiator side for a bank of SR flip-flops; the flops are the responders.
- Accepts a target word on a valid/ready handshake and computes per-bit set/reset excitation from the flops' current q feedback.
- Drives s/r for exactly one cycle, then watches q feedback until it matches the target or a timeout expires.
- Used wherever control logic must load state into SR-style storage without ever issuing the forbidden s=r=1 combination.

Parameters:
- WIDTH, 8: number of SR flip-flops driven (>=1).
- TIMEOUT, 4: WAIT-state cycles allowed for feedback to match the target before an error is flagged (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  target word valid
- in_ready  output  1  driver can accept a target word
- in_target  input  WIDTH  desired q value for each flop
- q_fb  input  WIDTH  q outputs of the driven flops
- s  output  WIDTH  set commands, registered
- r  output  WIDTH  reset commands, registered
- busy  output  1  request in progress (DRIVE or WAIT)
- done  output  1  one-cycle pulse: feedback matched target
- err  output  1  one-cycle pulse: timeout without match
- mismatch  output  WIDTH  failing bits (q_fb ^ target) latched on err

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports named clk and rst_n as elsewhere in the codebase.
- Reset values:
  - state=IDLE
  - s=0, r=0, done=0, err=0, busy=0
  - mismatch=0, internal target register=0, timeout counter=0
  - in_ready=1 once out of reset.
- Reset mid-operation: s/r drop to 0 immediately (asynchronously). No done or err is produced for the aborted request.
- in_ready = (state==IDLE), decoded from the state register. busy = (state!=IDLE).
- IDLE:
  - Handshake occurs when in_valid && in_ready at a rising edge.
  - On that edge: latch in_target; clear mismatch.
  - Load s <= in_target & ~q_fb and r <= ~in_target & q_fb, using q_fb sampled at that edge.
  - state -> DRIVE.
- DRIVE, exactly one cycle:
  - s/r are held stable for the whole cycle.
  - At the next edge: s <= 0, r <= 0, counter <= 0, state -> WAIT.
  - The external flops sample s/r at this same edge.
- WAIT:
  - Each edge, compare q_fb to the latched target.
  - Equal: done <= 1 for one cycle; state -> IDLE.
  - Not equal and counter == TIMEOUT-1: err <= 1 for one cycle; mismatch <= q_fb ^ target; state -> IDLE.
  - Otherwise: counter <= counter+1; stay in WAIT.
  - Counter width is clog2(TIMEOUT)+1 and it never wraps.
- Latency with an ideal SR flop:
  - Accept at edge 0, DRIVE in cycle 1, match sampled at edge 2.
  - done is high during the cycle following edge 2: two cycles after acceptance.
- Target equal to current q: s=r=0 during DRIVE, and done still follows with the same latency (deterministic, no shortcut).
- Invariant: (s & r)==0 in every cycle, including reset and abort.
- Excitation is computed once per request. q_fb changes during DRIVE do not alter s/r.
- done/err occur while state==IDLE, so in_ready=1 in the same cycle. A new request accepted then is legal and starts the next DRIVE immediately.
- done and err are mutually exclusive.
- mismatch holds its value until the next accepted request or reset.
- in_target and in_valid are ignored when in_ready=0.

Test Plan:
- Reset with all inputs at 0 -> s=r=0, done=err=busy=0, mismatch=0, in_ready=1; then assert rst_n during WAIT -> s=r=0 and state IDLE immediately, no pulse.
- With a behavioural SR bank model (q starts 0x00), send target 0xA5 -> s=0xA5, r=0x00 for exactly one cycle; done pulses 2 cycles after acceptance; q=0xA5.
- From q=0xA5, send target 0x5A -> s=0x5A, r=0xA5 for one cycle; done at +2; q=0x5A. Check (s&r)==0 every cycle.
- From q=0x5A, send target 0x5A -> s=r=0 throughout; done at +2.
- Model bit 0 stuck at 0, TIMEOUT=4, target 0xFF from 0x00 -> no done; err pulses after 4 WAIT cycles (acceptance +5); mismatch=0x01 and holds until the next accept.
- Hold in_valid high with targets 0x0F then 0xF0 back-to-back -> second accepted on the done cycle; no idle gap; both complete with done, never err.

Source files
------------

// File: rtl/sr_bank_driver.sv
// Initiator for a bank of SR flops: pulses set/reset for one cycle,
// then waits for q feedback to match the target or time out.
module sr_bank_driver #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] mismatch
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [CW-1:0]    cnt;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      s        <= '0;
      r        <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      mismatch <= '0;
      target   <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // s and r are disjoint by construction: s&r = 0
            target   <= in_target;
            mismatch <= '0;
            s        <= in_target & ~q_fb;
            r        <= ~in_target & q_fb;
            state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          s     <= '0;
          r     <= '0;
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (q_fb == target) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err      <= 1'b1;
            mismatch <= q_fb ^ target;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          s     <= '0;
          r     <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_driver.sv
// Directed bench for sr_bank_driver against a behavioural SR flop bank
// with an optional stuck-at-0 mask.
`timescale 1ns/1ps
module tb_sr_bank_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_target = 8'h00;
  logic [7:0] q_fb;
  logic [7:0] s, r;
  logic       busy, done, err;
  logic [7:0] mismatch;

  logic [7:0] stuck_lo = 8'h00;
  logic       q_load = 1'b0;
  logic [7:0] q_load_val = 8'h00;
  logic [7:0] q = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_bank_driver #(.WIDTH(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_target(in_target), .q_fb(q_fb),
    .s(s), .r(r), .busy(busy), .done(done), .err(err),
    .mismatch(mismatch)
  );

  // Behavioural SR bank: q+ = s | (q & ~r)
  always @(posedge clk) begin
    if (q_load) q <= q_load_val;
    else        q <= ((q & ~r) | s) & ~stuck_lo;
  end
  assign q_fb = q;

  always @(negedge clk) begin
    checks++;
    if ((s & r) !== 8'h00) begin
      errors++;
      $display("FAIL s_and_r: s=%h r=%h expected s&r=00", s, r);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_q(input logic [7:0] v);
    q_load = 1'b1;
    q_load_val = v;
    tick();
    q_load = 1'b0;
  endtask

  // One request; checks DRIVE values, done at +2, final q.
  task automatic do_req(input string nm, input logic [7:0] t,
                        input logic [7:0] es, input logic [7:0] er);
    in_valid = 1'b1;
    in_target = t;
    tick();
    in_valid = 1'b0;
    checks++;
    if (s !== es || r !== er || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_drive: s=%h r=%h busy=%b expected s=%h r=%h busy=1",
               nm, s, r, busy, es, er);
    end
    tick();
    checks++;
    if (s !== 8'h00 || r !== 8'h00 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_wait: s=%h r=%h done=%b expected 00 00 0",
               nm, s, r, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || in_ready !== 1'b1 || q !== t) begin
      errors++;
      $display("FAIL %s_done: done=%b err=%b rdy=%b q=%h expected 1 0 1 %h",
               nm, done, err, in_ready, q, t);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: done=%b busy=%b expected 0 0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (s !== 8'h00 || r !== 8'h00 || done !== 1'b0 || err !== 1'b0 ||
        busy !== 1'b0 || mismatch !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_vals: s=%h r=%h d=%b e=%b b=%b m=%h rdy=%b",
               s, r, done, err, busy, mismatch, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b busy=%b expected 1 0",
               in_ready, busy);
    end
    // Abort in DRIVE: s must fall asynchronously
    in_valid = 1'b1;
    in_target = 8'h3C;
    tick();
    in_valid = 1'b0;
    checks++;
    if (s !== 8'h3C || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: s=%h busy=%b expected 3c 1", s, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s !== 8'h00 || r !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_drive: s=%h r=%h busy=%b expected 00 00 0",
               s, r, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_q(8'h00);
    // Abort in WAIT
    in_valid = 1'b1;
    in_target = 8'h81;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s !== 8'h00 || r !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_wait: s=%h r=%h busy=%b rdy=%b expected 00 00 0 1",
               s, r, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL abort_nopulse: cyc=%0d done=%b err=%b expected 0 0",
                 i, done, err);
      end
    end
    load_q(8'h00);
  endtask

  task automatic test_set();
    do_req("set_a5", 8'hA5, 8'hA5, 8'h00);
  endtask

  task automatic test_flip();
    do_req("flip_5a", 8'h5A, 8'h5A, 8'hA5);
  endtask

  task automatic test_same();
    do_req("same_5a", 8'h5A, 8'h00, 8'h00);
  endtask

  task automatic test_timeout();
    load_q(8'h00);
    stuck_lo = 8'h01;
    in_valid = 1'b1;
    in_target = 8'hFF;
    tick();
    in_valid = 1'b0;
    checks++;
    if (s !== 8'hFF || r !== 8'h00) begin
      errors++;
      $display("FAIL to_drive: s=%h r=%h expected ff 00", s, r);
    end
    for (int i = 2; i <= 4; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL to_wait%0d: done=%b err=%b busy=%b expected 0 0 1",
                 i, done, err, busy);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL to_plus4: done=%b err=%b expected 0 0", done, err);
    end
    tick();
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || mismatch !== 8'h01 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_err: err=%b done=%b m=%h rdy=%b expected 1 0 01 1",
               err, done, mismatch, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (err !== 1'b0 || mismatch !== 8'h01) begin
        errors++;
        $display("FAIL to_hold%0d: err=%b m=%h expected 0 01", i, err, mismatch);
      end
    end
    stuck_lo = 8'h00;
    in_valid = 1'b1;
    in_target = 8'h00;
    tick();
    in_valid = 1'b0;
    checks++;
    if (mismatch !== 8'h00 || s !== 8'h00 || r !== 8'hFE) begin
      errors++;
      $display("FAIL to_clear: m=%h s=%h r=%h expected 00 00 fe",
               mismatch, s, r);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || q !== 8'h00) begin
      errors++;
      $display("FAIL to_recover: done=%b q=%h expected 1 00", done, q);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_target = 8'h0F;
    tick();
    in_target = 8'hF0;
    checks++;
    if (s !== 8'h0F || r !== 8'h00) begin
      errors++;
      $display("FAIL b2b_drive1: s=%h r=%h expected 0f 00", s, r);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || s !== 8'h00) begin
      errors++;
      $display("FAIL b2b_wait1: busy=%b s=%h expected 1 00", busy, s);
    end
    tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done1: done=%b err=%b rdy=%b expected 1 0 1",
               done, err, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || s !== 8'hF0 || r !== 8'h0F) begin
      errors++;
      $display("FAIL b2b_drive2: busy=%b done=%b s=%h r=%h expected 1 0 f0 0f",
               busy, done, s, r);
    end
    tick();
    checks++;
    if (err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait2: done=%b err=%b expected 0 0", done, err);
    end
    tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || q !== 8'hF0) begin
      errors++;
      $display("FAIL b2b_done2: done=%b err=%b q=%h expected 1 0 f0",
               done, err, q);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_set();
    test_flip();
    test_same();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
